// File: rtl/expu_stream_ctrl_pkg.sv
// Shared types for the exponential-unit stream controller: element formats,
// FSM state encoding and element width lookup.
package expu_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32'd32;
      FP64:    return 32'd64;
      FP16:    return 32'd16;
      FP8:     return 32'd8;
      FP16ALT: return 32'd16;
      default: return 32'd16;
    endcase
  endfunction

endpackage

// File: rtl/expu_stream_ctrl_tag_pipe.sv
// Tag shift register mirroring the expu pipeline; shifts only when the expu advances.
// The tag's valid flag is its MSB.
module expu_stream_ctrl_tag_pipe #(
  parameter int unsigned NUM_REGS = 0,
  parameter int unsigned TAG_W    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tail_o,
  output logic             any_valid_o
);

  if (NUM_REGS == 0) begin : g_wire
    logic unused_s;
    assign unused_s    = ^{clk_i, rst_ni, clear_i, en_i};
    assign tail_o      = tag_i;
    assign any_valid_o = 1'b0;
  end else begin : g_regs
    logic [TAG_W-1:0] stage_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < NUM_REGS; i++) stage_q[i] <= '0;
      end else if (clear_i) begin
        for (int i = 0; i < NUM_REGS; i++) stage_q[i] <= '0;
      end else if (en_i) begin
        stage_q[0] <= tag_i;
        for (int i = 1; i < NUM_REGS; i++) stage_q[i] <= stage_q[i-1];
      end else begin
        for (int i = 0; i < NUM_REGS; i++) stage_q[i] <= stage_q[i];
      end
    end

    always_comb begin
      any_valid_o = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) any_valid_o = any_valid_o | stage_q[i][TAG_W-1];
    end

    assign tail_o = stage_q[NUM_REGS-1];
  end

endmodule

// File: rtl/expu_stream_ctrl.sv
// Sequences one exponential job through expu_top: packs the element stream into
// N_ROWS-wide beats, tracks them with a tag pipe and flushes the tail with zero-strobe beats.
module expu_stream_ctrl
  import expu_stream_ctrl_pkg::*;
#(
  parameter fp_format_e  FPFORMAT = FP16ALT,
  parameter int unsigned N_ROWS   = 1,
  parameter int unsigned NUM_REGS = 0,
  parameter int unsigned LEN_W    = 16,
  localparam int unsigned WIDTH   = fp_width(FPFORMAT)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [LEN_W-1:0]          len_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      in_valid_i,
  input  logic [N_ROWS*WIDTH-1:0]   in_data_i,
  output logic                      in_ready_o,
  output logic                      expu_clear_o,
  output logic                      expu_en_o,
  output logic                      expu_valid_o,
  output logic                      expu_ready_o,
  output logic [N_ROWS-1:0]         expu_strb_o,
  output logic [N_ROWS*WIDTH-1:0]   expu_op_o,
  input  logic [N_ROWS*WIDTH-1:0]   expu_res_i,
  output logic                      out_valid_o,
  output logic [N_ROWS*WIDTH-1:0]   out_data_o,
  output logic [N_ROWS-1:0]         out_strb_o,
  output logic                      out_last_o,
  input  logic                      out_ready_i
);

  localparam int unsigned TAG_W = N_ROWS + 2;

  typedef struct packed {
    logic              valid;
    logic [N_ROWS-1:0] strb;
    logic              last;
  } expu_tag_t;

  ctrl_state_e       state_q, state_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [N_ROWS-1:0] last_strb_q, last_strb_d;

  logic [LEN_W-1:0]  rem_s, start_beats_s;
  logic [N_ROWS-1:0] start_strb_s, strb_s;
  logic              last_beat_s, adv_s, any_valid_s;
  expu_tag_t         tag_in_s, tail_s;

  // Beat count and last-beat lane mask for a new job, from the requested length.
  always_comb begin
    rem_s         = len_i % LEN_W'(N_ROWS);
    start_beats_s = (len_i / LEN_W'(N_ROWS)) + LEN_W'(rem_s != '0);
    for (int i = 0; i < N_ROWS; i++) begin
      start_strb_s[i] = (rem_s == '0) || (LEN_W'(i) < rem_s);
    end
  end

  assign last_beat_s = (beats_q == LEN_W'(1));
  assign strb_s      = last_beat_s ? last_strb_q : {N_ROWS{1'b1}};

  // Expu drive and tag generation; flush beats carry an all-zero tag.
  always_comb begin
    expu_valid_o = 1'b0;
    expu_strb_o  = '0;
    tag_in_s     = '0;
    case (state_q)
      RUN: begin
        expu_valid_o   = in_valid_i;
        expu_strb_o    = strb_s;
        tag_in_s.valid = in_valid_i;
        tag_in_s.strb  = strb_s;
        tag_in_s.last  = last_beat_s;
      end
      FLUSH:   expu_valid_o = 1'b1;
      default: expu_valid_o = 1'b0;
    endcase
  end

  assign busy_o       = (state_q == RUN) || (state_q == FLUSH);
  assign done_o       = (state_q == DONE);
  assign expu_ready_o = busy_o & (out_ready_i | ~tail_s.valid);
  assign in_ready_o   = (state_q == RUN) & expu_ready_o;
  assign adv_s        = expu_valid_o & expu_ready_o;
  assign expu_clear_o = clear_i;
  assign expu_en_o    = busy_o;
  assign expu_op_o    = in_data_i;
  assign out_data_o   = expu_res_i;
  assign out_valid_o  = tail_s.valid;
  assign out_strb_o   = tail_s.strb;
  assign out_last_o   = tail_s.last;

  expu_stream_ctrl_tag_pipe #(
    .NUM_REGS (NUM_REGS),
    .TAG_W    (TAG_W)
  ) i_tag_pipe (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .en_i        (adv_s),
    .tag_i       (tag_in_s),
    .tail_o      (tail_s),
    .any_valid_o (any_valid_s)
  );

  // Next-state logic; FLUSH ends on the cycle the last tag leaves the tail.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    last_strb_d = last_strb_q;
    case (state_q)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d     = RUN;
          beats_d     = start_beats_s;
          last_strb_d = start_strb_s;
        end else if (start_i) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (adv_s) begin
          beats_d = beats_q - LEN_W'(1);
          if (last_beat_s) begin
            state_d = (NUM_REGS == 0) ? DONE : FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        if (!any_valid_s || (adv_s && tail_s.valid && tail_s.last)) begin
          state_d = DONE;
        end else begin
          state_d = FLUSH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state; clear drops any job in flight without a done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      last_strb_q <= '0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      last_strb_q <= '0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      last_strb_q <= last_strb_d;
    end
  end

endmodule

// File: tb/tb_expu_stream_ctrl.sv
// Directed scoreboard bench for expu_stream_ctrl with N_ROWS=4, NUM_REGS=2 and a
// two-stage expu stand-in that applies a fixed XOR to each issued beat.
module tb_expu_stream_ctrl;
  import expu_stream_ctrl_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NREGS = 2;
  localparam int unsigned DW = NR * 16;
  localparam logic [63:0] XK = 64'h5A5A_3C3C_0F0F_9696;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  strb;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_i, start_i, in_valid_i, out_ready_i;
  logic [15:0] len_i;
  logic [DW-1:0] in_data_i, expu_op_o, expu_res_i, out_data_o;
  logic busy_o, done_o, in_ready_o, expu_clear_o, expu_en_o, expu_valid_o, expu_ready_o;
  logic out_valid_o, out_last_o;
  logic [NR-1:0] expu_strb_o, out_strb_o;

  logic [DW-1:0] m0_q, m1_q;
  exp_t sb_q[$];
  int n_asserts = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int flush_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_blocked = 1'b0;
  logic [63:0] held_data;
  logic [3:0] held_strb;
  logic held_last;
  int job_id = 0;

  expu_stream_ctrl #(
    .FPFORMAT (FP16ALT),
    .N_ROWS   (NR),
    .NUM_REGS (NREGS),
    .LEN_W    (16)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .expu_clear_o (expu_clear_o),
    .expu_en_o    (expu_en_o),
    .expu_valid_o (expu_valid_o),
    .expu_ready_o (expu_ready_o),
    .expu_strb_o  (expu_strb_o),
    .expu_op_o    (expu_op_o),
    .expu_res_i   (expu_res_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_strb_o   (out_strb_o),
    .out_last_o   (out_last_o),
    .out_ready_i  (out_ready_i)
  );

  always #5 clk = ~clk;

  // Expu stand-in: two registers that advance only on an issued beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q <= '0;
      m1_q <= '0;
    end else if (expu_clear_o) begin
      m0_q <= '0;
      m1_q <= '0;
    end else if (expu_valid_o && expu_ready_o) begin
      m0_q <= expu_op_o ^ XK;
      m1_q <= m0_q;
    end
  end
  assign expu_res_i = m1_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output-side monitor: scoreboard pops, hold-while-blocked, done/flush counting.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_blocked) begin
        check("hold_valid", 64'(out_valid_o), 64'd1);
        check("hold_data", out_data_o, held_data);
        check("hold_strb", 64'(out_strb_o), 64'(held_strb));
        check("hold_last", 64'(out_last_o), 64'(held_last));
      end
      if (out_valid_o && !out_ready_i) check("in_ready_blocked", 64'(in_ready_o), 64'd0);
      if (out_valid_o) check("out_strb_nonzero", 64'(out_strb_o != 4'b0000), 64'd1);
      if (out_valid_o && out_ready_i) begin
        check("sb_pop_avail", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_data", out_data_o, e.data);
          check("out_strb", 64'(out_strb_o), 64'(e.strb));
          check("out_last", 64'(out_last_o), 64'(e.last));
        end
      end
      prev_blocked = out_valid_o && !out_ready_i;
      held_data = out_data_o;
      held_strb = out_strb_o;
      held_last = out_last_o;
      if (done_o) done_cnt++;
      if (busy_o && expu_valid_o && expu_ready_o && expu_strb_o == 4'b0000) flush_cnt++;
    end
  end

  task automatic run_job(input int len, input bit gaps, input int stall_at, input int stall_len);
    int nb, b, cyc, rem, d0, f0, waitc;
    logic [3:0] exp_strb;
    exp_t e;
    nb = (len + 3) / 4;
    rem = len % 4;
    b = 0;
    cyc = 0;
    d0 = done_cnt;
    f0 = flush_cnt;
    job_id++;
    start_i = 1'b1;
    len_i = 16'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    while (b < nb && cyc < 200) begin
      in_valid_i = gaps ? ((cyc % 3) != 1) : 1'b1;
      in_data_i = {16'(job_id), 16'(b), 32'hC0DE_0000 ^ 32'(cyc)};
      out_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (in_valid_i && in_ready_o) begin
        exp_strb = (b == nb - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
        check("expu_strb", 64'(expu_strb_o), 64'(exp_strb));
        e.data = in_data_i ^ XK;
        e.strb = exp_strb;
        e.last = (b == nb - 1);
        sb_q.push_back(e);
        b++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("beats_fed", 64'(b), 64'(nb));
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    waitc = 0;
    while (done_cnt == d0 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("flush_beats", 64'(flush_cnt - f0), 64'd2);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    len_i = '0;
    in_valid_i = 1'b0;
    in_data_i = 64'h1234_5678_9ABC_DEF0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd0);
    check("rst_expu_valid", 64'(expu_valid_o), 64'd0);
    check("rst_expu_ready", 64'(expu_ready_o), 64'd0);
    check("rst_expu_en", 64'(expu_en_o), 64'd0);
    check("rst_expu_strb", 64'(expu_strb_o), 64'd0);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_strb", 64'(out_strb_o), 64'd0);
    check("rst_out_last", 64'(out_last_o), 64'd0);
    check("op_passthru", expu_op_o, 64'h1234_5678_9ABC_DEF0);
    check("res_passthru", out_data_o, m1_q);
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_job(8, 1'b0, -1, 0);
    run_job(6, 1'b0, -1, 0);

    d0 = done_cnt;
    start_i = 1'b1;
    len_i = 16'd0;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("l0_done", 64'(done_o), 64'd1);
    check("l0_expu_valid", 64'(expu_valid_o), 64'd0);
    check("l0_out_valid", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l0_done_pulse", 64'(done_o), 64'd0);
    check("l0_done_count", 64'(done_cnt - d0), 64'd1);
    @(posedge clk); #1;

    run_job(12, 1'b0, 1, 5);
    run_job(12, 1'b1, -1, 0);

    d0 = done_cnt;
    start_i = 1'b1;
    len_i = 16'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    check("clr_accept", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk);
    check("clr_in_flush_busy", 64'(busy_o), 64'd1);
    check("clr_in_flush_valid", 64'(expu_valid_o), 64'd1);
    check("clr_in_flush_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk); #1;
    clear_i = 1'b0;
    @(negedge clk);
    check("clr_out_valid", 64'(out_valid_o), 64'd0);
    check("clr_busy", 64'(busy_o), 64'd0);
    check("clr_expu_valid", 64'(expu_valid_o), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("clr_no_done", 64'(done_cnt - d0), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;

    run_job(4, 1'b0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
